mips_multicycle_ctrl: RTL

Moore FSM plus ALU decoder that sequences the 32-bit MIPS multi-cycle datapath.
- Decodes op/funct and the ALU zero flag into every datapath enable and mux select, one state per cycle.
- Sits beside the datapath inside the multi-cycle CPU top level, which also drives memwrite to memory.
- Supports lw, sw, R-type (add, sub, and, or, slt), beq, addi and j.

---
 rtl/mips_ctrl_pkg.sv | 44 ++++
 rtl/mips_alu_decoder.sv | 29 ++
 rtl/mips_multicycle_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multi-cycle MIPS controller (states, opcodes, functs, ALU codes).
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: maps aluop/funct to alucontrol; funct_bad flags an unknown funct under funct-decode.
// Ports: aluop[1:0], funct[5:0] in; alucontrol[2:0], funct_bad out. Purely combinational.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_bad
);

    always_comb begin
        alucontrol = ALU_ADD;
        funct_bad  = 1'b0;
        if (aluop == ALUOP_SUB) begin
            alucontrol = ALU_SUB;
        end else if (aluop == ALUOP_FUNCT) begin
            case (funct)
                F_ADD:   alucontrol = ALU_ADD;
                F_SUB:   alucontrol = ALU_SUB;
                F_AND:   alucontrol = ALU_AND;
                F_OR:    alucontrol = ALU_OR;
                F_SLT:   alucontrol = ALU_SLT;
                default: funct_bad = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore FSM sequencing the multi-cycle MIPS datapath (lw, sw, R-type, beq, addi, j).
// Ports: clk, reset (sync, active-low), op/funct from the IR, zero from the ALU; outputs are the datapath
// enables/selects, alucontrol, sticky illegal flag and state_dbg. Every output is held at 0 while reset==0.
// Optional: define CTRL_BNE_EN to add bne (op 000101) via the BNEEX state.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       kill_q, kill_d;
    logic       pcwrite, branch, bne, funct_bad;
    logic [1:0] aluop;
    logic [2:0] alu_ctl;

    mips_alu_decoder u_alu_dec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alu_ctl),
        .funct_bad  (funct_bad)
    );

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        kill_d    = 1'b0;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
`ifdef CTRL_BNE_EN
                    OP_BNE:       state_d = S_BNEEX;
`endif
                    default:      illegal_d = 1'b1;
                endcase
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            // An unknown funct is remembered so the following write-back is squashed.
            S_RTYPEEX: begin
                state_d   = S_RTYPEWB;
                kill_d    = funct_bad;
                illegal_d = illegal_q | funct_bad;
            end
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore decode; left at all-zero while reset is asserted.
    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        bne      = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        memwrite = 1'b0;
        alusrca  = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = ALUOP_ADD;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    alusrcb = 2'b01;
                end
                S_DECODE:  alusrcb = 2'b11;
                S_MEMADR, S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD:   iord = 1'b1;
                S_MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                S_MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                S_RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_FUNCT;
                end
                S_RTYPEWB: begin
                    regdst   = 1'b1;
                    regwrite = ~kill_q;
                end
                S_BEQEX: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_SUB;
                    pcsrc   = 2'b01;
                    branch  = 1'b1;
                end
`ifdef CTRL_BNE_EN
                // branch stays low here so a taken-on-equal path cannot fire for bne.
                S_BNEEX: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_SUB;
                    pcsrc   = 2'b01;
                    bne     = 1'b1;
                end
`endif
                S_ADDIWB:  regwrite = 1'b1;
                S_JEX: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pcen       = pcwrite | (branch & zero) | (bne & ~zero);
    assign alucontrol = reset ? alu_ctl : 3'b000;
    assign illegal    = reset & illegal_q;
    assign state_dbg  = reset ? state_q : 4'd0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            kill_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            kill_q    <= kill_d;
        end
    end

endmodule
